// File: rtl/raster_to_tile.sv
// raster_to_tile: accepts raster-order beats of four 24-bit pixels and emits
// 4x4 pixel tiles. One 4-row buffer is filled, then drained tile by tile.
// Optional feature macro: RASTER_TO_TILE_BGR_SWAP_EN (reverse the bytes of
// every pixel on output, BGR -> RGB). Undefined: pixels pass bit-exact.
module raster_to_tile #(
  parameter int TILES_PER_ROW = 480,
  parameter int TILE_ROWS     = 270
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic [95:0]  s_axis_tdata,
  input  logic         s_axis_tvalid,
  output logic         s_axis_tready,
  output logic [383:0] m_axis_tdata,
  output logic         m_axis_tvalid,
  input  logic         m_axis_tready,
  output logic         m_axis_tlast
);

  localparam int COL_W = (TILES_PER_ROW > 1) ? $clog2(TILES_PER_ROW) : 1;
  localparam int ROW_W = (TILE_ROWS > 1) ? $clog2(TILE_ROWS) : 1;
  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(TILES_PER_ROW - 1);
  localparam logic [ROW_W-1:0] TROW_LAST = ROW_W'(TILE_ROWS - 1);

  typedef enum logic {ST_FILL, ST_DRAIN} state_e;

  state_e             state_q, state_d;
  logic [COL_W-1:0]   wr_col_q, wr_col_d;
  logic [1:0]         wr_row_q, wr_row_d;
  logic [COL_W-1:0]   rd_col_q, rd_col_d;
  logic               rd_done_q, rd_done_d;
  logic [ROW_W-1:0]   tile_row_q, tile_row_d;
  logic               s_ready_q, s_ready_d;
  logic               rd_vld_q, rd_vld_d;
  logic               rd_end_q, rd_end_d;
  logic               skid_vld_q, skid_vld_d;
  logic               skid_end_q, skid_end_d;
  logic [383:0]       skid_data_q, skid_data_d;
  logic               m_valid_q, m_valid_d;
  logic               m_end_q, m_end_d;
  logic               m_last_q, m_last_d;
  logic [383:0]       m_data_q, m_data_d;

  logic               wr_en;
  logic               pop;
  logic               rd_issue;
  logic [1:0]         occ;
  logic [383:0]       raw_tile;
  logic [383:0]       rd_tile;

  function automatic logic [23:0] map_pixel(input logic [23:0] p);
`ifdef RASTER_TO_TILE_BGR_SWAP_EN
    return {p[7:0], p[15:8], p[23:16]};
`else
    return p;
`endif
  endfunction

  assign wr_en = s_axis_tvalid && s_ready_q;
  assign pop   = m_valid_q && m_axis_tready;
  // Tiles held in the read register, skid and output register after this
  // cycle's pop; at most two may be in flight so a stall never loses data.
  assign occ      = 2'(rd_vld_q) + 2'(skid_vld_q) + 2'(m_valid_q) - 2'(pop);
  assign rd_issue = (state_q == ST_DRAIN) && !rd_done_q && (occ < 2'd2);

  // Row banks: one write port from the raster stream, one registered read port.
  for (genvar b = 0; b < 4; b++) begin : bank_g
    logic [95:0] mem [TILES_PER_ROW];
    logic [95:0] rd_q;
    // NOTE: buffer memories carry no reset so they map onto block RAM; stale
    // contents are never read before being overwritten by the next fill.
    always_ff @(posedge aclk) begin
      if (wr_en && (wr_row_q == 2'(b))) mem[wr_col_q] <= s_axis_tdata;
      if (rd_issue) rd_q <= mem[rd_col_q];
    end
  end

  assign raw_tile = {bank_g[3].rd_q, bank_g[2].rd_q, bank_g[1].rd_q, bank_g[0].rd_q};

  // Per-pixel byte mapping applied to the tile read from the banks.
  always_comb begin
    rd_tile = '0;
    for (int i = 0; i < 16; i++) rd_tile[24*i +: 24] = map_pixel(raw_tile[24*i +: 24]);
  end

  // Next-state logic: fill counters, read issue, output/skid pipeline.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // (which would infer a latch).
    state_d     = state_q;
    wr_col_d    = wr_col_q;
    wr_row_d    = wr_row_q;
    rd_col_d    = rd_col_q;
    rd_done_d   = rd_done_q;
    tile_row_d  = tile_row_q;
    skid_vld_d  = skid_vld_q;
    skid_end_d  = skid_end_q;
    skid_data_d = skid_data_q;
    m_valid_d   = m_valid_q;
    m_end_d     = m_end_q;
    m_last_d    = m_last_q;
    m_data_d    = m_data_q;
    rd_vld_d    = rd_issue;
    rd_end_d    = rd_issue && (rd_col_q == COL_LAST);

    if (wr_en) begin
      if (wr_col_q == COL_LAST) begin
        wr_col_d = '0;
        if (wr_row_q == 2'd3) begin
          wr_row_d = '0;
          state_d  = ST_DRAIN;
        end else begin
          wr_row_d = wr_row_q + 2'd1;
        end
      end else begin
        wr_col_d = wr_col_q + COL_W'(1);
      end
    end

    if (rd_issue) begin
      if (rd_col_q == COL_LAST) rd_done_d = 1'b1;
      else                      rd_col_d  = rd_col_q + COL_W'(1);
    end

    if (!m_valid_q || m_axis_tready) begin
      if (skid_vld_q) begin
        m_valid_d   = 1'b1;
        m_data_d    = skid_data_q;
        m_end_d     = skid_end_q;
        m_last_d    = skid_end_q && (tile_row_q == TROW_LAST);
        skid_vld_d  = rd_vld_q;
        skid_data_d = rd_tile;
        skid_end_d  = rd_end_q;
      end else if (rd_vld_q) begin
        m_valid_d = 1'b1;
        m_data_d  = rd_tile;
        m_end_d   = rd_end_q;
        m_last_d  = rd_end_q && (tile_row_q == TROW_LAST);
      end else begin
        m_valid_d = 1'b0;
      end
    end else if (rd_vld_q) begin
      skid_vld_d  = 1'b1;
      skid_data_d = rd_tile;
      skid_end_d  = rd_end_q;
    end

    if (pop && m_end_q) begin
      state_d    = ST_FILL;
      wr_col_d   = '0;
      wr_row_d   = '0;
      rd_col_d   = '0;
      rd_done_d  = 1'b0;
      tile_row_d = (tile_row_q == TROW_LAST) ? '0 : tile_row_q + ROW_W'(1);
    end

    s_ready_d = (state_d == ST_FILL);
  end

  // Control and output registers, cleared asynchronously.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= ST_FILL;
      wr_col_q    <= '0;
      wr_row_q    <= '0;
      rd_col_q    <= '0;
      rd_done_q   <= 1'b0;
      tile_row_q  <= '0;
      s_ready_q   <= 1'b0;
      rd_vld_q    <= 1'b0;
      rd_end_q    <= 1'b0;
      skid_vld_q  <= 1'b0;
      skid_end_q  <= 1'b0;
      skid_data_q <= '0;
      m_valid_q   <= 1'b0;
      m_end_q     <= 1'b0;
      m_last_q    <= 1'b0;
      m_data_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      wr_col_q    <= wr_col_d;
      wr_row_q    <= wr_row_d;
      rd_col_q    <= rd_col_d;
      rd_done_q   <= rd_done_d;
      tile_row_q  <= tile_row_d;
      s_ready_q   <= s_ready_d;
      rd_vld_q    <= rd_vld_d;
      rd_end_q    <= rd_end_d;
      skid_vld_q  <= skid_vld_d;
      skid_end_q  <= skid_end_d;
      skid_data_q <= skid_data_d;
      m_valid_q   <= m_valid_d;
      m_end_q     <= m_end_d;
      m_last_q    <= m_last_d;
      m_data_q    <= m_data_d;
    end
  end

  assign s_axis_tready = s_ready_q;
  assign m_axis_tvalid = m_valid_q;
  assign m_axis_tlast  = m_last_q;
  assign m_axis_tdata  = m_data_q;

endmodule

// File: tb/tb_raster_to_tile.sv
// Testbench for raster_to_tile, run with a reduced geometry (8 tiles per row,
// 3 tile-rows per frame). Honours RASTER_TO_TILE_BGR_SWAP_EN like the design.
module tb_raster_to_tile;

  localparam int TPR = 8;
  localparam int TR  = 3;

  logic         clk;
  logic         aresetn;
  logic [95:0]  s_axis_tdata;
  logic         s_axis_tvalid;
  logic         s_axis_tready;
  logic [383:0] m_axis_tdata;
  logic         m_axis_tvalid;
  logic         m_axis_tready;
  logic         m_axis_tlast;

  raster_to_tile #(.TILES_PER_ROW(TPR), .TILE_ROWS(TR)) dut (
    .aclk          (clk),
    .aresetn       (aresetn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast)
  );

  typedef struct {
    int          r;
    int          k;
    int          c;
    logic [23:0] exp;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int last_hs_cyc = 0;
  int m_trow  = 0;
  int frame_tlast_cnt = 0;
  int frame_tlast_pos = -1;
  int frame_tile = 0;

  logic [23:0]  pix [4][4*TPR];
  logic [383:0] got_tiles [TPR];
  vec_t         tbl [8];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time exhausted");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [399:0] got, input logic [399:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [23:0] exp_pixel(input logic [23:0] p);
`ifdef RASTER_TO_TILE_BGR_SWAP_EN
    return {p[7:0], p[15:8], p[23:16]};
`else
    return p;
`endif
  endfunction

  // Reference tile k: rows 0..3 of the buffered raster, pixel columns 4k..4k+3.
  function automatic logic [383:0] exp_tile(input int k);
    logic [383:0] t;
    t = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        t[96*r + 24*c +: 24] = exp_pixel(pix[r][4*k + c]);
    return t;
  endfunction

  function automatic logic [23:0] pattern_in(input int r, input int k, input int p);
    return {8'(k), 8'(4*r + p), 8'h5A};
  endfunction

  function automatic logic [23:0] pattern_out(input int r, input int k, input int c);
`ifdef RASTER_TO_TILE_BGR_SWAP_EN
    return {8'h5A, 8'(4*r + c), 8'(k)};
`else
    return {8'(k), 8'(4*r + c), 8'h5A};
`endif
  endfunction

  // Push 4*TPR accepted beats; gap_pct is the chance of an idle cycle.
  task automatic fill_row(input bit patterned, input int gap_pct);
    int n = 0;
    int iters = 0;
    bit rdy;
    logic [95:0] beat;
    while (n < 4*TPR) begin
      @(negedge clk);
      rdy = s_axis_tready;
      for (int p = 0; p < 4; p++)
        beat[24*p +: 24] = patterned ? pattern_in(n / TPR, n % TPR, p) : 24'($urandom);
      if (int'($urandom_range(99)) < gap_pct) begin
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = ~beat;
      end else begin
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = beat;
      end
      @(posedge clk);
      #1;
      if (s_axis_tvalid && rdy) begin
        for (int p = 0; p < 4; p++) pix[n / TPR][4*(n % TPR) + p] = beat[24*p +: 24];
        n++;
        last_hs_cyc = cyc;
      end
      iters++;
      if (iters > 40*TPR + 100) begin
        check("fill_timeout", n, 4*TPR);
        s_axis_tvalid = 1'b0;
        return;
      end
    end
  endtask

  // Collect TPR tiles; ready_pct is the chance m_axis_tready is high.
  // abort_at >= 0 pulses reset right after that many tiles.
  task automatic drain_row(input int ready_pct, input int abort_at);
    int k = 0;
    int iters = 0;
    int s_hi = 0;
    bit rdy;
    bit stalled = 1'b0;
    bit first_seen = 1'b0;
    bit held_last = 1'b0;
    logic [383:0] held = '0;
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    while (k < TPR) begin
      if (s_axis_tready) s_hi++;
      if (m_axis_tvalid && !first_seen) begin
        first_seen = 1'b1;
        check("fill_to_drain_latency", cyc, last_hs_cyc + 2);
      end
      if (stalled)
        check("stall_hold", {m_axis_tvalid, m_axis_tlast, m_axis_tdata}, {1'b1, held_last, held});
      rdy = (int'($urandom_range(99)) < ready_pct);
      m_axis_tready = rdy;
      stalled   = m_axis_tvalid && !rdy;
      held      = m_axis_tdata;
      held_last = m_axis_tlast;
      if (m_axis_tvalid && rdy) begin
        check("tile_data", m_axis_tdata, exp_tile(k));
        check("tile_last", m_axis_tlast, (m_trow == TR-1) && (k == TPR-1));
        if (m_axis_tlast) begin
          frame_tlast_cnt++;
          frame_tlast_pos = frame_tile;
        end
        got_tiles[k] = m_axis_tdata;
        k++;
        frame_tile++;
        if (k == abort_at) begin
          @(posedge clk);
          #2;
          aresetn = 1'b0;
          #1;
          check("rst_mid_tvalid", m_axis_tvalid, 1'b0);
          check("rst_mid_tready", s_axis_tready, 1'b0);
          check("rst_mid_tdata", m_axis_tdata, '0);
          m_axis_tready = 1'b0;
          @(negedge clk);
          @(negedge clk);
          aresetn = 1'b1;
          @(posedge clk);
          #1;
          check("rst_mid_release_tready", s_axis_tready, 1'b1);
          m_trow = 0;
          return;
        end
      end
      iters++;
      if (iters > 20*TPR + 50) begin
        check("drain_timeout", k, TPR);
        m_axis_tready = 1'b0;
        return;
      end
      @(negedge clk);
    end
    m_axis_tready = 1'b0;
    check("tvalid_after_last_tile", m_axis_tvalid, 1'b0);
    check("tready_after_drain", s_axis_tready, 1'b1);
    check("tready_low_during_drain", s_hi, 0);
    m_trow = (m_trow == TR-1) ? 0 : m_trow + 1;
  endtask

  task automatic begin_frame();
    frame_tlast_cnt = 0;
    frame_tlast_pos = -1;
    frame_tile = 0;
  endtask

  task automatic end_frame();
    check("frame_tlast_count", frame_tlast_cnt, 1);
    check("frame_tlast_pos", frame_tlast_pos, TR*TPR - 1);
  endtask

  // Compare captured tiles of a patterned row against the fixed table.
  task automatic run_table();
    logic [383:0] t;
    for (int i = 0; i < 8; i++) begin
      t = got_tiles[tbl[i].k];
      check("table_pixel", t[96*tbl[i].r + 24*tbl[i].c +: 24], tbl[i].exp);
    end
  endtask

  initial begin
    tbl[0] = '{0, 0, 0, pattern_out(0, 0, 0)};
    tbl[1] = '{0, 0, 3, pattern_out(0, 0, 3)};
    tbl[2] = '{1, 2, 1, pattern_out(1, 2, 1)};
    tbl[3] = '{2, 5, 2, pattern_out(2, 5, 2)};
    tbl[4] = '{3, 7, 3, pattern_out(3, 7, 3)};
    tbl[5] = '{3, 0, 0, pattern_out(3, 0, 0)};
    tbl[6] = '{0, 7, 0, pattern_out(0, 7, 0)};
    tbl[7] = '{2, 4, 3, pattern_out(2, 4, 3)};

    aresetn       = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    m_axis_tready = 1'b0;
    #1 aresetn = 1'b0;
    #1;
    check("reset_m_tvalid", m_axis_tvalid, 1'b0);
    check("reset_m_tlast", m_axis_tlast, 1'b0);
    check("reset_m_tdata", m_axis_tdata, '0);
    check("reset_s_tready", s_axis_tready, 1'b0);
    @(negedge clk);
    @(negedge clk);
    aresetn = 1'b1;
    @(posedge clk);
    #1;
    check("tready_after_reset", s_axis_tready, 1'b1);

    // Frame 1: patterned row, gapped/stalled random row, clean random row.
    begin_frame();
    fill_row(1'b1, 0);
    drain_row(100, -1);
    run_table();
    fill_row(1'b0, 30);
    drain_row(50, -1);
    fill_row(1'b0, 0);
    drain_row(100, -1);
    end_frame();

    // Frame 2: tlast must reappear at the same position.
    begin_frame();
    for (int i = 0; i < TR; i++) begin
      fill_row(1'b0, 20);
      drain_row(60, -1);
    end
    end_frame();

    // One row so tile_row is non-zero, then reset mid-drain.
    fill_row(1'b0, 0);
    drain_row(100, -1);
    fill_row(1'b1, 10);
    drain_row(70, 5);

    // Fresh frame after reset: first row patterned with gaps.
    begin_frame();
    fill_row(1'b1, 30);
    drain_row(100, -1);
    run_table();
    for (int i = 1; i < TR; i++) begin
      fill_row(1'b0, 10);
      drain_row(50, -1);
    end
    end_frame();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
